// File: rtl/audio_voice_sched.sv
// Shares the single codec sample path between the BGM note source and a one-shot SFX
// requester; SFX preempts BGM for a fixed sample count while BGM phase keeps running.
module audio_voice_sched #(
  parameter int                  SAMPLE_W = 24,
  parameter int                  PERIOD_W = 7,
  parameter int                  LEN_W    = 16,
  parameter logic [SAMPLE_W-1:0] SFX_AMP  = 24'h3F0000
) (
  input  logic                clk100,
  input  logic                rst,
  input  logic                enable,
  input  logic                new_sample,
  input  logic [PERIOD_W-1:0] bgm_period,
  input  logic                sfx_req,
  input  logic [PERIOD_W-1:0] sfx_period,
  input  logic [LEN_W-1:0]    sfx_len,
  output logic                sfx_ack,
  output logic                sfx_busy,
  output logic [1:0]          active_src,
  output logic                hphone_valid,
  output logic [SAMPLE_W-1:0] audio_l_in,
  output logic [SAMPLE_W-1:0] audio_r_in
);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_BGM = 2'd1,
    S_SFX = 2'd2
  } state_t;

  // >= rather than == so a period that shrinks mid-note still wraps
  function automatic logic [PERIOD_W-1:0] phase_next(input logic [PERIOD_W-1:0] ph,
                                                     input logic [PERIOD_W-1:0] per);
    return (ph >= per) ? '0 : ph + 1'b1;
  endfunction

  function automatic logic [SAMPLE_W-1:0] bgm_sample(input logic [PERIOD_W-1:0] ph,
                                                     input logic [PERIOD_W-1:0] per);
    return (per == '0) ? '0 : {ph, {(SAMPLE_W-PERIOD_W){1'b0}}};
  endfunction

  function automatic logic [SAMPLE_W-1:0] sfx_sample(input logic [PERIOD_W-1:0] ph,
                                                     input logic [PERIOD_W-1:0] per);
    return ((per != '0) && (ph <= (per >> 1))) ? SFX_AMP : '0;
  endfunction

  state_t                state_q, state_d;
  logic [PERIOD_W-1:0]   bgm_phase_q, bgm_phase_d;
  logic [PERIOD_W-1:0]   sfx_phase_q, sfx_phase_d;
  logic [PERIOD_W-1:0]   sfx_per_q, sfx_per_d;
  logic [LEN_W-1:0]      sfx_rem_q, sfx_rem_d;
  logic                  sfx_ack_q, sfx_ack_d;
  logic                  valid_q, valid_d;
  logic [SAMPLE_W-1:0]   audio_q, audio_d;
  logic                  accept;

  // the ack cycle still sees the held request; it must not be accepted twice
  assign accept = (state_q == S_BGM) && sfx_req && !sfx_ack_q;

  always_comb begin
    state_d     = state_q;
    bgm_phase_d = bgm_phase_q;
    sfx_phase_d = sfx_phase_q;
    sfx_per_d   = sfx_per_q;
    sfx_rem_d   = sfx_rem_q;
    sfx_ack_d   = 1'b0;
    valid_d     = 1'b0;
    audio_d     = '0;
    if (!enable) begin
      state_d     = S_OFF;
      bgm_phase_d = '0;
      sfx_phase_d = '0;
      sfx_rem_d   = '0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_BGM;
        S_BGM: begin
          if (new_sample) begin
            valid_d     = 1'b1;
            audio_d     = bgm_sample(bgm_phase_q, bgm_period);
            bgm_phase_d = phase_next(bgm_phase_q, bgm_period);
          end
          if (accept) begin
            sfx_ack_d   = 1'b1;
            sfx_per_d   = sfx_period;
            sfx_phase_d = '0;
            sfx_rem_d   = sfx_len;
            if (sfx_len != '0) state_d = S_SFX;
          end
        end
        S_SFX: begin
          if (new_sample) begin
            valid_d     = 1'b1;
            audio_d     = sfx_sample(sfx_phase_q, sfx_per_q);
            bgm_phase_d = phase_next(bgm_phase_q, bgm_period);
            sfx_phase_d = phase_next(sfx_phase_q, sfx_per_q);
            sfx_rem_d   = sfx_rem_q - 1'b1;
            if (sfx_rem_q == LEN_W'(1)) state_d = S_BGM;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q     <= S_OFF;
      bgm_phase_q <= '0;
      sfx_phase_q <= '0;
      sfx_per_q   <= '0;
      sfx_rem_q   <= '0;
      sfx_ack_q   <= 1'b0;
      valid_q     <= 1'b0;
      audio_q     <= '0;
    end else begin
      state_q     <= state_d;
      bgm_phase_q <= bgm_phase_d;
      sfx_phase_q <= sfx_phase_d;
      sfx_per_q   <= sfx_per_d;
      sfx_rem_q   <= sfx_rem_d;
      sfx_ack_q   <= sfx_ack_d;
      valid_q     <= valid_d;
      audio_q     <= audio_d;
    end
  end

  assign sfx_ack      = sfx_ack_q;
  assign sfx_busy     = (state_q == S_SFX);
  assign active_src   = state_q;
  assign hphone_valid = valid_q;
  assign audio_l_in   = audio_q;
  assign audio_r_in   = audio_q;

endmodule

// File: tb/tb_audio_voice_sched.sv
// Randomized plus directed scoreboard bench for audio_voice_sched against a behavioural model.
module tb_audio_voice_sched;

  logic        clk100 = 1'b0;
  logic        rst_i = 1'b1, en_i = 1'b0, stb_i = 1'b0, req_i = 1'b0;
  logic [6:0]  bper_i = '0, sper_i = '0;
  logic [15:0] slen_i = '0;
  logic        sfx_ack, sfx_busy, hphone_valid;
  logic [1:0]  active_src;
  logic [23:0] audio_l_in, audio_r_in;

  always #5 clk100 = ~clk100;

  audio_voice_sched dut (
    .clk100(clk100), .rst(rst_i), .enable(en_i), .new_sample(stb_i),
    .bgm_period(bper_i), .sfx_req(req_i), .sfx_period(sper_i), .sfx_len(slen_i),
    .sfx_ack(sfx_ack), .sfx_busy(sfx_busy), .active_src(active_src),
    .hphone_valid(hphone_valid), .audio_l_in(audio_l_in), .audio_r_in(audio_r_in)
  );

  typedef struct packed {
    logic       ack;
    logic       busy;
    logic [1:0] src;
    logic       valid;
  } exp_t;

  exp_t        ctl_q[$];
  logic [23:0] smp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: mode 0 = off, 1 = bgm, 2 = sfx
  int m_mode = 0, m_bph = 0, m_sph = 0, m_sper = 0, m_rem = 0;
  bit m_ack = 0;

  function automatic int adv(int ph, int per);
    return (ph >= per) ? 0 : ph + 1;
  endfunction

  task automatic model_step();
    exp_t        e;
    logic [23:0] smp;
    bit          v, a;
    smp = '0; v = 0; a = 0;
    if (rst_i || !en_i) begin
      m_mode = 0; m_bph = 0; m_sph = 0; m_rem = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (stb_i) begin
        v = 1;
        smp = (bper_i == 0) ? 24'd0 : 24'(m_bph * 131072);
        m_bph = adv(m_bph, int'(bper_i));
      end
      if (req_i && !m_ack) begin
        a = 1; m_sper = int'(sper_i); m_sph = 0; m_rem = int'(slen_i);
        if (m_rem != 0) m_mode = 2;
      end
    end else begin
      if (stb_i) begin
        v = 1;
        smp = (m_sper != 0 && m_sph <= m_sper / 2) ? 24'h3F0000 : 24'd0;
        m_bph = adv(m_bph, int'(bper_i));
        m_sph = adv(m_sph, m_sper);
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = 1;
      end
    end
    m_ack = a;
    e.ack = a; e.busy = (m_mode == 2); e.src = 2'(m_mode); e.valid = v;
    ctl_q.push_back(e);
    if (v) smp_q.push_back(smp);
  endtask

  // One clock of stimulus: the requester drops sfx_req once it sees the ack
  task automatic step();
    if (m_ack) req_i = 1'b0;
    model_step();
    @(posedge clk100);
    #1;
  endtask

  task automatic idle(int n);
    stb_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobes(int n, int gap);
    for (int i = 0; i < n; i++) begin
      stb_i = 1'b1; step();
      idle(gap);
    end
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  // Monitor: one control expectation per cycle, samples popped whenever valid is seen
  initial begin
    exp_t        e;
    logic [23:0] w;
    forever begin
      @(negedge clk100);
      if (ctl_q.size() > 0) begin
        e = ctl_q.pop_front();
        check("sfx_ack", 32'(sfx_ack), 32'(e.ack));
        check("sfx_busy", 32'(sfx_busy), 32'(e.busy));
        check("active_src", 32'(active_src), 32'(e.src));
        check("hphone_valid", 32'(hphone_valid), 32'(e.valid));
        if (hphone_valid) begin
          if (smp_q.size() == 0) begin
            check("unexpected_sample", 32'(audio_l_in), 32'hFFFFFFFF);
          end else begin
            w = smp_q.pop_front();
            check("audio_l", 32'(audio_l_in), 32'(w));
            check("audio_r", 32'(audio_r_in), 32'(w));
          end
        end else begin
          if (e.valid && smp_q.size() > 0) void'(smp_q.pop_front());
          check("audio_l_idle", 32'(audio_l_in), 32'd0);
          check("audio_r_idle", 32'(audio_r_in), 32'd0);
        end
      end
    end
  end

  initial begin
    // reset and start-up
    rst_i = 1'b1; en_i = 1'b0;
    idle(3);
    rst_i = 1'b0; en_i = 1'b1;
    idle(2);
    // BGM ramp with period 3
    bper_i = 7'd3;
    strobes(8, 2);
    // SFX period 3, length 4 preempting BGM
    sper_i = 7'd3; slen_i = 16'd4; req_i = 1'b1;
    idle(2);
    strobes(7, 2);
    // zero-length SFX, then a request held while busy
    slen_i = 16'd0; req_i = 1'b1;
    strobes(4, 1);
    sper_i = 7'd5; slen_i = 16'd5; req_i = 1'b1;
    strobes(2, 1);
    sper_i = 7'd2; slen_i = 16'd2; req_i = 1'b1;
    strobes(10, 1);
    // reset for 3 cycles mid-SFX with a request pending
    sper_i = 7'd4; slen_i = 16'd20; req_i = 1'b1;
    strobes(3, 1);
    req_i = 1'b1; slen_i = 16'd3;
    rst_i = 1'b1; stb_i = 1'b1; step(); step(); step();
    rst_i = 1'b0; stb_i = 1'b0;
    strobes(6, 1);
    // enable drop mid-SFX
    sper_i = 7'd6; slen_i = 16'd30; req_i = 1'b1;
    strobes(3, 1);
    en_i = 1'b0;
    strobes(3, 0);
    en_i = 1'b1;
    idle(2);
    // period shrink 5 -> 2 at phase 4, then rest period
    bper_i = 7'd5;
    strobes(4, 1);
    bper_i = 7'd2;
    strobes(3, 1);
    bper_i = 7'd0;
    strobes(3, 1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      en_i  = ($urandom_range(0, 199) != 0);
      stb_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0)
        bper_i = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
      if (!req_i && !m_ack && $urandom_range(0, 29) == 0) begin
        req_i  = 1'b1;
        sper_i = 7'($urandom_range(0, 12));
        slen_i = 16'($urandom_range(0, 7));
      end
      step();
    end
    rst_i = 1'b0; en_i = 1'b1; stb_i = 1'b0;
    repeat (3) @(posedge clk100);
    check("queues_drained", 32'(ctl_q.size() + smp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
